// File: rtl/mc_datapath.sv
// Multi-cycle RV32I-subset datapath: FETCH/DECODE/EXEC/MEM/WB over one shared req/ack memory port.
// Optional MC_DATAPATH_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module mc_datapath #(
    parameter int             XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int             NREGS    = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted
`ifdef MC_DATAPATH_RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_count
`endif
);
    localparam int SHW = $clog2(XLEN);
    localparam int RIW = $clog2(NREGS);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_OPI = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t          state_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] pc_q, npc_q, a_q, b_q, imm_q, res_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            req_q, we_q, retire_q, halted_q;
    logic [XLEN-1:0] rf_q [NREGS];
`ifdef MC_DATAPATH_RETIRE_CNT_EN
    logic [31:0]     cnt_q;
`endif

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    logic       is_op, is_opi, is_ld, is_st, is_br, legal_d, taken_d, wr_rd;
    logic [XLEN-1:0] imm_d, op2, alu_core, alu_d, npc_d;
    logic [SHW-1:0]  shamt;

    assign opc    = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];
    assign is_op  = (opc == OPC_OP);
    assign is_opi = (opc == OPC_OPI);
    assign is_ld  = (opc == OPC_LD);
    assign is_st  = (opc == OPC_ST);
    assign is_br  = (opc == OPC_BR);
    assign wr_rd  = (is_op || is_opi || is_ld) && (rd != 5'd0) && (int'(rd) < NREGS);

    function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NREGS) return '0;
        return rf_q[idx[RIW-1:0]];
    endfunction

    always_comb begin
        legal_d = 1'b0;
        case (opc)
            OPC_OP:  legal_d = (f7 == 7'b0000000) ||
                               (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            OPC_OPI: legal_d = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
                               (f3 == 3'b110) || (f3 == 3'b111);
            OPC_LD,
            OPC_ST:  legal_d = (f3 == 3'b010);
            OPC_BR:  legal_d = (f3 != 3'b010) && (f3 != 3'b011);
            default: legal_d = 1'b0;
        endcase
    end

    always_comb begin
        imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        if (is_st)
            imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        else if (is_br)
            imm_d = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    end

    // Shifts only exist in the register form, so shamt always comes from rs2.
    assign op2   = is_op ? b_q : imm_q;
    assign shamt = b_q[SHW-1:0];

    always_comb begin
        alu_core = '0;
        case (f3)
            3'b000: alu_core = (is_op && f7[5]) ? a_q - op2 : a_q + op2;
            3'b001: alu_core = a_q << shamt;
            3'b010: alu_core = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(op2)};
            3'b011: alu_core = {{(XLEN-1){1'b0}}, a_q < op2};
            3'b100: alu_core = a_q ^ op2;
            3'b101: alu_core = f7[5] ? XLEN'($signed(a_q) >>> shamt) : a_q >> shamt;
            3'b110: alu_core = a_q | op2;
            default: alu_core = a_q & op2;
        endcase
        alu_d = (is_ld || is_st) ? a_q + imm_q : alu_core;
    end

    always_comb begin
        taken_d = 1'b0;
        case (f3)
            3'b000: taken_d = (a_q == b_q);
            3'b001: taken_d = (a_q != b_q);
            3'b100: taken_d = $signed(a_q) < $signed(b_q);
            3'b101: taken_d = $signed(a_q) >= $signed(b_q);
            3'b110: taken_d = a_q < b_q;
            3'b111: taken_d = a_q >= b_q;
            default: taken_d = 1'b0;
        endcase
        npc_d = (is_br && taken_d) ? pc_q + imm_q : pc_q + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            npc_q    <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= RESET_PC;
            wdata_q  <= '0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
`ifdef MC_DATAPATH_RETIRE_CNT_EN
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: if (mem_ack) begin
                    ir_q    <= mem_rdata[31:0];
                    req_q   <= 1'b0;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q   <= rd_reg(rs1);
                    b_q   <= rd_reg(rs2);
                    imm_q <= imm_d;
                    if (legal_d) begin
                        state_q <= S_EXEC;
                    end else begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end
                end
                S_EXEC: begin
                    res_q <= alu_d;
                    npc_q <= npc_d;
                    if (is_ld || is_st) begin
                        req_q   <= 1'b1;
                        we_q    <= is_st;
                        addr_q  <= alu_d;
                        wdata_q <= b_q;
                        state_q <= S_MEM;
                    end else begin
                        retire_q <= 1'b1;
                        state_q  <= S_WB;
                    end
                end
                S_MEM: if (mem_ack) begin
                    if (!we_q) res_q <= mem_rdata;
                    req_q    <= 1'b0;
                    we_q     <= 1'b0;
                    retire_q <= 1'b1;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    if (wr_rd) rf_q[rd[RIW-1:0]] <= res_q;
                    pc_q     <= npc_q;
                    retire_q <= 1'b0;
                    req_q    <= 1'b1;
                    we_q     <= 1'b0;
                    addr_q   <= npc_q;
                    state_q  <= S_FETCH;
`ifdef MC_DATAPATH_RETIRE_CNT_EN
                    cnt_q    <= cnt_q + 32'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Reset abandons any in-flight request immediately, not one cycle later.
    assign mem_req   = req_q & ~reset;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q & ~reset;
    assign halted    = halted_q & ~reset;
`ifdef MC_DATAPATH_RETIRE_CNT_EN
    assign retire_count = cnt_q;
`endif
endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: a memory model serves requests, expected retires and stores
// are queued by the stimulus and checked by monitors as the DUT produces them.
module tb_mc_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
`ifdef MC_DATAPATH_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    mc_datapath #(.XLEN(32), .RESET_PC(32'h0), .NREGS(32)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc), .retire(retire), .halted(halted)
`ifdef MC_DATAPATH_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int dcyc; logic [31:0] npc; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

    ret_t        rq[$];
    st_t         sq[$];
    int          total = 0, bad = 0;
    logic [31:0] mem [0:255];
    int          waits = 0;
    logic        model_ack = 1'b0, force_ack = 1'b0;
    logic [31:0] rdata_r = 32'hDEADBEEF;
    logic        pend = 1'b0;

    assign mem_ack   = model_ack | force_ack;
    assign mem_rdata = rdata_r;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'h63};
    endfunction

    // Memory model: serves after `waits` stall cycles, checks request stability and stores.
    int          wcnt = 0;
    logic [31:0] cap_addr, cap_wd;
    logic        cap_we;
    always @(negedge clk) begin
        model_ack = 1'b0;
        rdata_r   = 32'hDEADBEEF;
        if (mem_req) begin
            if (wcnt == 0) begin
                cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
            end else begin
                chk("req_hold", {mem_we, mem_addr, (cap_we ? mem_wdata : cap_wd)},
                    {cap_we, cap_addr, cap_wd});
            end
            if (wcnt >= waits) begin
                model_ack = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    if (sq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_store: got addr %0h data %0h expected none",
                                 mem_addr, mem_wdata);
                    end else begin
                        st_t e;
                        e = sq.pop_front();
                        chk("store_addr", mem_addr, e.addr);
                        chk("store_data", mem_wdata, e.data);
                    end
                end else begin
                    rdata_r = mem[mem_addr[9:2]];
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Retire monitor: spacing between retires and the pc visible the cycle after.
    int          cyc = 0, last = 0;
    logic [31:0] pend_pc;
    always @(negedge clk) begin
        if (reset) begin
            cyc = 0; last = 0; pend = 1'b0;
        end else begin
            cyc++;
            if (pend) begin
                chk("next_pc", pc, pend_pc);
                pend = 1'b0;
            end
            if (retire) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_retire: got retire at pc %0h expected none", pc);
                end else begin
                    ret_t e;
                    e = rq.pop_front();
                    chk("retire_cycles", cyc - last, e.dcyc);
                    pend = 1'b1;
                    pend_pc = e.npc;
                end
                last = cyc;
            end
        end
    end

    task automatic exp_ret(input int dcyc, input logic [31:0] npc);
        ret_t e;
        e.dcyc = dcyc; e.npc = npc;
        rq.push_back(e);
    endtask
    task automatic exp_st(input logic [31:0] a, input logic [31:0] d);
        st_t e;
        e.addr = a; e.data = d;
        sq.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFFFFFF;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_retire", retire, 1'b0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", halted, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((rq.size() != 0 || sq.size() != 0 || pend) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d retires/%0d stores pending expected 0",
                     nm, rq.size(), sq.size());
            rq.delete(); sq.delete();
        end
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 20 && !halted; i++) begin
            @(negedge clk); #1;
        end
        chk("halted", halted, 1'b1);
    endtask

    initial begin
        // Phase 1: zero-wait ALU, x0, stores and BLT taken, ends on illegal at 0x40.
        clear_mem();
        waits = 0;
        mem[0]  = i_t(5, 0, 3'b000, 1, 7'h13);        // ADDI x1,x0,5
        mem[1]  = i_t(-7, 1, 3'b000, 2, 7'h13);       // ADDI x2,x1,-7
        mem[2]  = s_t(256, 2, 0);                     // SW x2,0x100(x0)
        mem[3]  = i_t(9, 0, 3'b000, 0, 7'h13);        // ADDI x0,x0,9
        mem[4]  = r_t(7'h00, 0, 0, 3'b000, 4);        // ADD x4,x0,x0
        mem[5]  = s_t(260, 4, 0);                     // SW x4,0x104(x0)
        mem[6]  = r_t(7'h20, 2, 1, 3'b000, 5);        // SUB x5,x1,x2
        mem[7]  = s_t(264, 5, 0);                     // SW x5,0x108(x0)
        mem[8]  = b_t(16, 1, 2, 3'b100);              // BLT x2,x1,+16
        mem[12] = r_t(7'h20, 1, 2, 3'b101, 6);        // SRA x6,x2,x1
        mem[13] = r_t(7'h00, 1, 2, 3'b010, 7);        // SLT x7,x2,x1
        mem[14] = s_t(268, 6, 0);                     // SW x6,0x10C(x0)
        mem[15] = s_t(272, 7, 0);                     // SW x7,0x110(x0)
        exp_ret(4, 32'h04); exp_ret(4, 32'h08); exp_ret(5, 32'h0C); exp_ret(4, 32'h10);
        exp_ret(4, 32'h14); exp_ret(5, 32'h18); exp_ret(4, 32'h1C); exp_ret(5, 32'h20);
        exp_ret(4, 32'h30); exp_ret(4, 32'h34); exp_ret(4, 32'h38); exp_ret(5, 32'h3C);
        exp_ret(5, 32'h40);
        exp_st(32'h100, 32'hFFFFFFFE); exp_st(32'h104, 32'h0); exp_st(32'h108, 32'h7);
        exp_st(32'h10C, 32'hFFFFFFFF); exp_st(32'h110, 32'h1);
        do_reset();
        @(negedge clk); #1;
        chk("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0});
        wait_done("p1");
        wait_halt();
        repeat (20) begin
            @(negedge clk); #1;
            chk("halt_hold", {halted, mem_req}, 2'b10);
`ifdef MC_DATAPATH_RETIRE_CNT_EN
            chk("retire_count", retire_count, 32'd13);
`endif
        end
        chk("halt_pc", pc, 32'h40);

        // Phase 2: 3 wait cycles per ack; SW/LW through 0xC and BLTU not taken at 0x20.
        clear_mem();
        waits = 3;
        mem[0] = i_t(5, 0, 3'b000, 1, 7'h13);         // ADDI x1,x0,5
        mem[1] = i_t(-7, 1, 3'b000, 2, 7'h13);        // ADDI x2,x1,-7
        mem[2] = b_t(8, 0, 0, 3'b000);                // BEQ x0,x0,+8
        mem[3] = 32'hFFFFFFFE;                        // data word at 0xC
        mem[4] = s_t(12, 2, 0);                       // SW x2,12(x0)
        mem[5] = i_t(12, 0, 3'b010, 3, 7'h03);        // LW x3,12(x0)
        mem[6] = s_t(256, 3, 0);                      // SW x3,0x100(x0)
        mem[7] = i_t(0, 0, 3'b000, 0, 7'h13);         // ADDI x0,x0,0
        mem[8] = b_t(16, 1, 2, 3'b110);               // BLTU x2,x1,+16
        exp_ret(7, 32'h04); exp_ret(7, 32'h08); exp_ret(7, 32'h10); exp_ret(11, 32'h14);
        exp_ret(11, 32'h18); exp_ret(11, 32'h1C); exp_ret(7, 32'h20); exp_ret(7, 32'h24);
        exp_st(32'hC, 32'hFFFFFFFE); exp_st(32'h100, 32'hFFFFFFFE);
        do_reset();
        wait_done("p2");
        wait_halt();
        chk("bltu_halt_pc", pc, 32'h24);

        // Phase 3: reset during a pending load with ack forced high.
        clear_mem();
        waits = 3;
        mem[0]  = i_t(7, 0, 3'b000, 3, 7'h13);        // ADDI x3,x0,7
        mem[1]  = i_t(256, 0, 3'b010, 3, 7'h03);      // LW x3,0x100(x0)
        mem[64] = 32'h00000055;
        exp_ret(7, 32'h04);
        do_reset();
        wait_done("p3a");
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 50 && !found; i++) begin
                @(negedge clk); #2;
                found = mem_req && !mem_we && (mem_addr == 32'h100);
            end
            chk("load_req_seen", found, 1'b1);
        end
        reset = 1'b1;
        force_ack = 1'b1;
        #1 chk("req_in_reset", mem_req, 1'b0);
        mem[0] = s_t(260, 3, 0);                      // SW x3,0x104(x0)
        mem[1] = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk); #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", mem_req, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        force_ack = 1'b0;
        exp_ret(11, 32'h04);
        exp_st(32'h104, 32'h0);
        @(negedge clk); #1;
        chk("refetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0});
        wait_done("p3b");
        wait_halt();
        chk("p3_halt_pc", pc, 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised multi-cycle RV32I-subset datapath: the successor to our single-cycle datapath. It replaces the combinational instruction and data ROM/RAM with one shared external memory port using a req/ack handshake, and sequences each instruction through a fetch/decode/execute/memory/writeback state machine. It holds its own register file, ALU, immediate extension and branch compare. It sits between the top level and the memory arbiter.

## Interface
Parameters:
- XLEN, 32: datapath width; 32 or 64. Instructions are always 32 bits.
- RESET_PC, 0: PC loaded on reset.
- NREGS, 32: register count; 16 or 32. Indices ≥ NREGS read 0; writes to them are dropped.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (SW), 0 = read
- mem_addr  out  XLEN  byte address
- mem_wdata  out  XLEN  store data (rs2)
- mem_ack  in  1  request completes this cycle
- mem_rdata  in  XLEN  read data, valid when mem_ack=1; fetch uses [31:0]
- pc  out  XLEN  current instruction address
- retire  out  1  one-cycle pulse when an instruction commits
- halted  out  1  core stopped on an illegal instruction

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack, latch the IR from mem_rdata[31:0], then go to DECODE.
- DECODE: read rs1/rs2 and latch A/B. Build the I, S or B immediate, sign-extended to XLEN; the B immediate has 13 bits with bit0 = 0. An unsupported opcode or funct goes to HALT.
- EXEC: the ALU computes and latches its result. LOAD/STORE go to MEM. All other instructions go to WB.
- MEM: mem_req=1, mem_addr = rs1+imm, mem_we=1 for SW. On mem_ack, latch mem_rdata for LW, then go to WB.
- WB: write rd (OP, OP-IMM, LW) unless rd=x0. Update pc and pulse retire, then go to FETCH.
- Supported instructions:
  - OP: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA. Shift amount is the low log2(XLEN) bits of B.
  - OP-IMM: ADDI, ANDI, ORI, XORI, SLTI.
  - LW and SW with funct3=010. For XLEN=64, a full XLEN word is transferred.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Next pc: pc+imm for a taken branch, otherwise pc+4. Arithmetic wraps modulo 2^XLEN.
- x0 always reads 0.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 until mem_ack.
  - mem_ack is sampled only while mem_req=1; an ack with no request is ignored.
  - Ack may arrive in the same cycle the request is raised.
  - There is no timeout; the core waits indefinitely.
- HALT: mem_req=0 and halted=1. pc holds the address of the illegal instruction. Only reset exits HALT.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, all registers 0, retire=0, halted=0, mem_req=0 during the reset cycle.
- The first fetch request appears in the first cycle after reset deasserts.
- Reset asserted mid-transaction abandons the request. A mem_ack in that cycle is ignored, and no register or pc write occurs.
- Cycle counts with zero-wait memory (ack in the same cycle as req):
  - OP, OP-IMM and branch: 4 cycles per instruction.
  - LW and SW: 5 cycles per instruction.
  - Each wait cycle on an ack adds 1 cycle.
- retire is high exactly in the WB cycle. The new pc and register value are visible the following cycle.
- The register write and pc update in WB take effect at the same edge.

## Configuration
- MC_DATAPATH_RETIRE_CNT_EN defined:
  - Adds output retire_count (out, 32 bits): a counter of retired instructions.
  - Reset value 0; increments on each retire pulse; wraps from 0xFFFFFFFF to 0.
  - Frozen in HALT.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then ADDI x1,x0,5 and ADDI x2,x1,-7, zero-wait memory.
  - Required: x2 = 0xFFFFFFFE.
  - Required: retire pulses at cycles 4 and 8 after reset release; pc = 8.
- SW x2,12(x0) then LW x3,12(x0), with 3 wait cycles on every ack.
  - Required: the store shows mem_we=1, addr=0xC, wdata=0xFFFFFFFE, all held stable for 4 cycles.
  - Required: x3 = 0xFFFFFFFE.
  - Required: each instruction takes 5+6 cycles.
- BLT x2,x1,+16 with x2 = -2 and x1 = 5 at pc = 0x20.
  - Required: branch taken, pc = 0x30.
  - Repeat with BLTU: not taken, pc = 0x24.
- ADDI x0,x0,9 then ADD x4,x0,x0.
  - Required: x4 = 0.
- Fetch 0xFFFFFFFF at pc = 0x40.
  - Required: halted=1 and mem_req=0 for 20 cycles; pc = 0x40; retire_count (if enabled) unchanged.
- Reset asserted while mem_req=1 on a load, with mem_ack high in the same cycle.
  - Required: rd unchanged, pc = RESET_PC, mem_req=0 that cycle, fetch restarts.
